if_fetch_unit: RTL and testbench

Instruction-fetch initiator for the OpenMIPS pipeline. It owns the program counter and drives chip-enable and address to the combinational instruction ROM. It captures the returned instruction word into a 2-entry fetch queue and presents PC/instruction pairs to the decode stage over a valid/ready handshake. It also handles pipeline stalls, branch redirects and queue flushes.

---
 rtl/if_fetch_unit.sv | 121 ++++++++++++
 tb/tb_if_fetch_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`timescale 1ns/1ps
// if_fetch_unit: instruction-fetch initiator. Owns the PC, drives the
// combinational instruction ROM and buffers returned words in a 2-entry
// queue that feeds decode over a valid/ready handshake.
//
// Handshake: a head entry moves to decode on a rising edge where
// id_valid_o and id_ready_i are both 1. Once id_valid_o is 1, id_pc_o and
// id_inst_o hold until that transfer or until a redirect flushes the queue.
// id_ready_i may drop at any time.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        dbg_state,
  output logic [1:0]  dbg_count
);

  typedef enum logic {
    RST_WAIT = 1'b0,
    FETCH    = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] q_pc   [2];
  logic [31:0] q_inst [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        push;
  logic        pop;
  logic        unused_target_bits;

  // Redirect targets are always word aligned; the low bits carry no meaning.
  assign unused_target_bits = ^branch_target_i[1:0];

  assign rom_addr_o = pc;
  assign dbg_state  = state;
  assign dbg_count  = count;

  // Head view comes from the queue registers only; zero when empty.
  assign id_valid_o = (count != 2'd0);
  assign id_pc_o    = id_valid_o ? q_pc[head]   : 32'h0;
  assign id_inst_o  = id_valid_o ? q_inst[head] : 32'h0;

  // Transfer to decode, and acceptance of the word the ROM is returning now.
  assign pop  = id_valid_o & id_ready_i;
  assign push = (state == FETCH) & ~stall_i & ~branch_flag_i &
                ((count != 2'd2) | pop);

  // Two-state controller: wait one edge after reset release, then fetch forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RST_WAIT;
      rom_ce_o <= 1'b0;
    end else begin
      case (state)
        RST_WAIT: begin
          state    <= FETCH;
          rom_ce_o <= 1'b1;
        end
        FETCH: begin
          state    <= FETCH;
          rom_ce_o <= 1'b1;
        end
        default: begin
          state    <= RST_WAIT;
          rom_ce_o <= 1'b0;
        end
      endcase
    end
  end

  // PC and fetch queue: redirect flushes and wins over everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      q_pc[0]   <= 32'h0;
      q_pc[1]   <= 32'h0;
      q_inst[0] <= 32'h0;
      q_inst[1] <= 32'h0;
    end else if (state == FETCH) begin
      if (branch_flag_i) begin
        pc    <= {branch_target_i[31:2], 2'b00};
        head  <= 1'b0;
        tail  <= 1'b0;
        count <= 2'd0;
      end else begin
        if (push) begin
          q_pc[tail]   <= pc;
          q_inst[tail] <= rom_inst_i;
          tail         <= ~tail;
          pc           <= pc + 32'd4;
        end
        if (pop) begin
          head <= ~head;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
// Bench for if_fetch_unit: directed sequence covering startup, backpressure,
// full-queue streaming, redirect, stall drain, PC wrap and async reset.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        dbg_state;
  logic [1:0]  dbg_count;

  int n_checks = 0;
  int n_errors = 0;
  logic        mon_en = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] a0, h0, held;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .rom_ce_o        (rom_ce),
    .rom_addr_o      (rom_addr),
    .rom_inst_i      (rom_inst),
    .stall_i         (stall),
    .branch_flag_i   (branch_flag),
    .branch_target_i (branch_target),
    .id_valid_o      (id_valid),
    .id_ready_i      (id_ready),
    .id_pc_o         (id_pc),
    .id_inst_o       (id_inst),
    .dbg_state       (dbg_state),
    .dbg_count       (dbg_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word[i] = 32'h1000_0000 + i, zero while disabled
  assign rom_inst = rom_ce ? (32'h1000_0000 + (rom_addr >> 2)) : 32'h0;

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // program-order expectation starting at pc
  task automatic fill(input logic [31:0] start);
    logic [31:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({p, rom_word(p)});
      p = p + 32'd4;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard: every transfer to decode must match the program order;
  // a transfer coinciding with a redirect is discarded
  always @(negedge clk) begin
    if (mon_en && rst && id_valid && id_ready && !branch_flag) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", {id_pc, id_inst}, 64'hx);
      end else begin
        check("sb_pair", {id_pc, id_inst}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; branch_flag = 1'b0;
    branch_target = 32'h0; id_ready = 1'b1;

    // reset state
    step(2);
    check("rst_ce",    {63'h0, rom_ce},   64'h0);
    check("rst_addr",  {32'h0, rom_addr}, 64'h0);
    check("rst_valid", {63'h0, id_valid}, 64'h0);
    check("rst_pc",    {32'h0, id_pc},    64'h0);
    check("rst_inst",  {32'h0, id_inst},  64'h0);
    check("rst_count", {62'h0, dbg_count}, 64'h0);
    check("rst_state", {63'h0, dbg_state}, 64'h0);

    // startup
    fill(32'h0);
    mon_en = 1'b1;
    rst = 1'b1;
    #1;
    check("pre_e0_ce", {63'h0, rom_ce}, 64'h0);
    step(1);
    check("e0_ce",    {63'h0, rom_ce},   64'h1);
    check("e0_valid", {63'h0, id_valid}, 64'h0);
    check("e0_state", {63'h0, dbg_state}, 64'h1);
    step(1);
    check("e1_valid", {63'h0, id_valid}, 64'h1);
    check("e1_head",  {id_pc, id_inst},  {32'h0, 32'h1000_0000});
    step(5);
    check("stream_count", {62'h0, dbg_count}, 64'h1);

    // backpressure
    id_ready = 1'b0;
    a0 = rom_addr;
    h0 = id_pc;
    check("bp_head_lag", {32'h0, h0}, {32'h0, a0 - 32'd4});
    step(5);
    check("bp_count", {62'h0, dbg_count}, 64'h2);
    check("bp_addr",  {32'h0, rom_addr},  {32'h0, a0 + 32'd4});
    check("bp_head",  {id_pc, id_inst},   {h0, rom_word(h0)});
    check("bp_ce",    {63'h0, rom_ce},    64'h1);

    // simultaneous push/pop at full
    id_ready = 1'b1;
    step(1);
    check("full_count1", {62'h0, dbg_count}, 64'h2);
    check("full_head1",  {32'h0, id_pc},     {32'h0, h0 + 32'd4});
    check("full_addr1",  {32'h0, rom_addr},  {32'h0, a0 + 32'd8});
    step(1);
    check("full_count2", {62'h0, dbg_count}, 64'h2);
    check("full_head2",  {32'h0, id_pc},     {32'h0, h0 + 32'd8});

    // redirect while full
    branch_flag = 1'b1;
    branch_target = 32'h0000_0043;
    fill(32'h0000_0040);
    step(1);
    branch_flag = 1'b0;
    check("rd_valid", {63'h0, id_valid}, 64'h0);
    check("rd_count", {62'h0, dbg_count}, 64'h0);
    check("rd_addr",  {32'h0, rom_addr}, 64'h40);
    check("rd_pc0",   {32'h0, id_pc},    64'h0);
    step(1);
    check("rd_tgt_valid", {63'h0, id_valid}, 64'h1);
    check("rd_tgt_head",  {id_pc, id_inst},  {32'h40, 32'h1000_0010});
    step(2);

    // stall drain with a full queue
    id_ready = 1'b0;
    step(1);
    check("st_fill", {62'h0, dbg_count}, 64'h2);
    id_ready = 1'b1;
    stall = 1'b1;
    held = rom_addr;
    step(1);
    check("st_count1", {62'h0, dbg_count}, 64'h1);
    check("st_addr1",  {32'h0, rom_addr},  {32'h0, held});
    step(2);
    check("st_count3", {62'h0, dbg_count}, 64'h0);
    check("st_valid3", {63'h0, id_valid},  64'h0);
    check("st_addr3",  {32'h0, rom_addr},  {32'h0, held});
    stall = 1'b0;
    step(1);
    check("st_resume", {id_pc, id_inst}, {held, rom_word(held)});
    step(2);

    // PC wrap
    branch_flag = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    fill(32'hFFFF_FFF8);
    step(1);
    branch_flag = 1'b0;
    check("wr_addr", {32'h0, rom_addr}, 64'hFFFF_FFF8);
    step(1);
    check("wr_pc0", {32'h0, id_pc}, 64'hFFFF_FFF8);
    step(1);
    check("wr_pc1", {32'h0, id_pc}, 64'hFFFF_FFFC);
    step(1);
    check("wr_pc2", {id_pc, id_inst}, {32'h0, 32'h1000_0000});
    step(2);

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("ar_ce",    {63'h0, rom_ce},    64'h0);
    check("ar_addr",  {32'h0, rom_addr},  64'h0);
    check("ar_valid", {63'h0, id_valid},  64'h0);
    check("ar_pc",    {32'h0, id_pc},     64'h0);
    check("ar_inst",  {32'h0, id_inst},   64'h0);
    check("ar_count", {62'h0, dbg_count}, 64'h0);
    check("ar_state", {63'h0, dbg_state}, 64'h0);
    mon_en = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
